// File: rtl/ibex_obi_host_arbiter.sv
// N-host to 1-device arbiter for the Ibex req/gnt/rvalid protocol.
// Each granted request's host index is queued so that in-order responses can be routed back to it.
module ibex_obi_host_arbiter #(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumHosts-1:0]                   host_req_i,
  output logic [NumHosts-1:0]                   host_gnt_o,
  input  logic [NumHosts*AddrWidth-1:0]         host_addr_i,
  input  logic [NumHosts-1:0]                   host_we_i,
  input  logic [NumHosts*DataWidth/8-1:0]       host_be_i,
  input  logic [NumHosts*DataWidth-1:0]         host_wdata_i,
  output logic [NumHosts-1:0]                   host_rvalid_o,
  output logic [DataWidth-1:0]                  host_rdata_o,
  output logic                                  host_err_o,
  output logic                                  dev_req_o,
  input  logic                                  dev_gnt_i,
  output logic [AddrWidth-1:0]                  dev_addr_o,
  output logic                                  dev_we_o,
  output logic [DataWidth/8-1:0]                dev_be_o,
  output logic [DataWidth-1:0]                  dev_wdata_o,
  input  logic                                  dev_rvalid_i,
  input  logic [DataWidth-1:0]                  dev_rdata_i,
  input  logic                                  dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_rsp_o
);

  localparam int unsigned IdW  = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  // Handshake: a host transfer happens when host_req_i[i] & host_gnt_o[i]; the device transfer
  // when dev_req_o & dev_gnt_i; responses are single-cycle pulses on rvalid with no back-pressure.

  logic [IdW-1:0]  arb_sel, sel, base, cand;
  logic [IdW-1:0]  lock_idx_q, lock_idx_d, rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IdW-1:0]  id_mem_q [MaxOutstanding];
  logic [IdW-1:0]  head_id;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            spur_q, spur_d;
  logic            any_req, full, fifo_empty, push, pop;
  int              sum;

  assign any_req    = |host_req_i;
  assign full       = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);

  // Scan from the base index upward with wrap; iterating in reverse leaves the nearest requester.
  always_comb begin
    arb_sel = '0;
    cand    = '0;
    sum     = 0;
    base    = RoundRobin ? rr_ptr_q : '0;
    for (int i = int'(NumHosts) - 1; i >= 0; i--) begin
      sum = int'(base) + i;
      if (sum >= int'(NumHosts)) sum = sum - int'(NumHosts);
      cand = IdW'(sum);
      if (host_req_i[cand]) arb_sel = cand;
    end
  end

  // A stalled request keeps its host selected so the device sees a stable address.
  assign sel = (lock_q && host_req_i[lock_idx_q]) ? lock_idx_q : arb_sel;

  assign dev_req_o   = rst_ni & ~full & any_req;
  assign push        = dev_req_o & dev_gnt_i;
  assign pop         = rst_ni & dev_rvalid_i & ~fifo_empty;
  assign head_id     = id_mem_q[rd_ptr_q];

  assign dev_addr_o  = host_addr_i[sel*AddrWidth +: AddrWidth];
  assign dev_we_o    = host_we_i[sel];
  assign dev_be_o    = host_be_i[sel*BeW +: BeW];
  assign dev_wdata_o = host_wdata_i[sel*DataWidth +: DataWidth];

  assign host_rdata_o   = dev_rdata_i;
  assign host_err_o     = dev_err_i;
  assign outstanding_o  = cnt_q;
  assign spurious_rsp_o = spur_q;

  always_comb begin
    host_gnt_o          = '0;
    host_gnt_o[sel]     = push;
    host_rvalid_o       = '0;
    host_rvalid_o[head_id] = pop;
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    spur_d     = spur_q | (dev_rvalid_i & fifo_empty);

    if (push) begin
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (RoundRobin) rr_ptr_d = (sel == IdW'(NumHosts - 1)) ? '0 : sel + 1'b1;
    end else if (dev_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (lock_q && !host_req_i[lock_idx_q]) begin
      lock_d = 1'b0;
    end

    if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;

    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      spur_q     <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) id_mem_q[i] <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      spur_q     <= spur_d;
      if (push) id_mem_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_ibex_obi_host_arbiter.sv
// Directed bench: a 2-host fixed-priority arbiter and a 3-host round-robin arbiter side by side.
module tb_ibex_obi_host_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: 2 hosts, fixed priority, MaxOutstanding=2
  logic [1:0]  a_req, a_gnt, a_we, a_rvalid;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_be;
  logic [31:0] a_rdata, a_daddr, a_dwdata, a_drdata;
  logic        a_err, a_dreq, a_dgnt, a_dwe, a_dvalid, a_derr, a_spur;
  logic [3:0]  a_dbe;
  logic [1:0]  a_out;

  // Instance B: 3 hosts, round-robin, MaxOutstanding=2
  logic [2:0]  b_req, b_gnt, b_we, b_rvalid;
  logic [95:0] b_addr, b_wdata;
  logic [11:0] b_be;
  logic [31:0] b_rdata, b_daddr, b_dwdata, b_drdata;
  logic        b_err, b_dreq, b_dgnt, b_dwe, b_dvalid, b_derr, b_spur;
  logic [3:0]  b_dbe;
  logic [1:0]  b_out;

  ibex_obi_host_arbiter #(
    .NumHosts(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .RoundRobin(1'b0)
  ) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(a_req), .host_gnt_o(a_gnt), .host_addr_i(a_addr), .host_we_i(a_we),
    .host_be_i(a_be), .host_wdata_i(a_wdata), .host_rvalid_o(a_rvalid),
    .host_rdata_o(a_rdata), .host_err_o(a_err),
    .dev_req_o(a_dreq), .dev_gnt_i(a_dgnt), .dev_addr_o(a_daddr), .dev_we_o(a_dwe),
    .dev_be_o(a_dbe), .dev_wdata_o(a_dwdata), .dev_rvalid_i(a_dvalid),
    .dev_rdata_i(a_drdata), .dev_err_i(a_derr),
    .outstanding_o(a_out), .spurious_rsp_o(a_spur)
  );

  ibex_obi_host_arbiter #(
    .NumHosts(3), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2), .RoundRobin(1'b1)
  ) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(b_req), .host_gnt_o(b_gnt), .host_addr_i(b_addr), .host_we_i(b_we),
    .host_be_i(b_be), .host_wdata_i(b_wdata), .host_rvalid_o(b_rvalid),
    .host_rdata_o(b_rdata), .host_err_o(b_err),
    .dev_req_o(b_dreq), .dev_gnt_i(b_dgnt), .dev_addr_o(b_daddr), .dev_we_o(b_dwe),
    .dev_be_o(b_dbe), .dev_wdata_o(b_dwdata), .dev_rvalid_i(b_dvalid),
    .dev_rdata_i(b_drdata), .dev_err_i(b_derr),
    .outstanding_o(b_out), .spurious_rsp_o(b_spur)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_req = '0; a_addr = {32'h200, 32'h100}; a_we = 2'b10; a_be = {4'h3, 4'hF};
    a_wdata = {32'h22222222, 32'h11111111};
    a_dgnt = 1'b0; a_dvalid = 1'b0; a_drdata = '0; a_derr = 1'b0;
    b_req = '0; b_addr = {32'h3000, 32'h2000, 32'h1000}; b_we = '0; b_be = '0; b_wdata = '0;
    b_dgnt = 1'b0; b_dvalid = 1'b0; b_drdata = '0; b_derr = 1'b0;

    // ---- reset: outputs held quiet even with active inputs
    #1 rst_n = 1'b0;
    a_req = 2'b11; a_dgnt = 1'b1; a_dvalid = 1'b1;
    b_req = 3'b111; b_dgnt = 1'b1; b_dvalid = 1'b1;
    #2;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_dreq", a_dreq, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_a_spur", a_spur, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_b_out", b_out, 0);
    a_req = '0; a_dgnt = 1'b0; a_dvalid = 1'b0;
    b_req = '0; b_dgnt = 1'b0; b_dvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // ---- fixed priority with payload mux
    step;
    chk("post_rst_spur", a_spur, 0);
    a_req = 2'b11; a_dgnt = 1'b1;
    #1;
    chk("fp0_gnt", a_gnt, 2'b01);
    chk("fp0_dreq", a_dreq, 1);
    chk("fp0_addr", a_daddr, 32'h100);
    chk("fp0_we", a_dwe, 0);
    chk("fp0_be", a_dbe, 4'hF);
    chk("fp0_wdata", a_dwdata, 32'h11111111);
    step;
    chk("fp1_out", a_out, 1);
    a_dvalid = 1'b1; a_drdata = 32'h1;
    #1;
    chk("fp1_gnt", a_gnt, 2'b01);
    chk("fp1_rvalid", a_rvalid, 2'b01);
    step;
    chk("fp2_out", a_out, 1);
    a_req = 2'b10; a_drdata = 32'h2;
    #1;
    chk("fp2_gnt", a_gnt, 2'b10);
    chk("fp2_addr", a_daddr, 32'h200);
    chk("fp2_we", a_dwe, 1);
    chk("fp2_be", a_dbe, 4'h3);
    chk("fp2_wdata", a_dwdata, 32'h22222222);
    chk("fp2_rvalid", a_rvalid, 2'b01);
    step;
    chk("fp3_out", a_out, 1);
    a_req = 2'b00;
    #1;
    chk("fp3_gnt", a_gnt, 0);
    chk("fp3_dreq", a_dreq, 0);
    chk("fp3_rvalid", a_rvalid, 2'b10);

    // ---- spurious response with empty queue
    step;
    chk("sp_out0", a_out, 0);
    chk("sp_before", a_spur, 0);
    #1;
    chk("sp_rvalid", a_rvalid, 0);
    step;
    a_dvalid = 1'b0;
    chk("sp_sticky", a_spur, 1);
    chk("sp_out", a_out, 0);

    // ---- outstanding limit
    a_req = 2'b01; a_dgnt = 1'b1;
    #1;
    chk("ol0_gnt", a_gnt, 2'b01);
    step;
    chk("ol1_out", a_out, 1);
    #1;
    chk("ol1_gnt", a_gnt, 2'b01);
    step;
    chk("ol2_out", a_out, 2);
    #1;
    chk("ol2_dreq", a_dreq, 0);
    chk("ol2_gnt", a_gnt, 0);
    a_dvalid = 1'b1;
    #1;
    chk("ol2_full_rv_gnt", a_gnt, 0);
    chk("ol2_full_rv", a_rvalid, 2'b01);
    step;
    a_dvalid = 1'b0;
    chk("ol3_out", a_out, 1);
    #1;
    chk("ol3_dreq", a_dreq, 1);
    chk("ol3_gnt", a_gnt, 2'b01);
    step;
    chk("ol4_out", a_out, 2);
    a_req = '0; a_dvalid = 1'b1;
    #1;
    chk("ol4_rvalid", a_rvalid, 2'b01);
    step;
    chk("ol5_out", a_out, 1);
    #1;
    chk("ol5_rvalid", a_rvalid, 2'b01);
    step;
    a_dvalid = 1'b0;
    chk("ol6_out", a_out, 0);

    // ---- response routing: host1 then host0
    a_req = 2'b10;
    #1;
    chk("rt0_gnt", a_gnt, 2'b10);
    step;
    a_req = 2'b01;
    #1;
    chk("rt1_gnt", a_gnt, 2'b01);
    step;
    a_req = '0; a_dvalid = 1'b1; a_drdata = 32'hAAAA; a_derr = 1'b0;
    #1;
    chk("rt2_rvalid", a_rvalid, 2'b10);
    chk("rt2_rdata", a_rdata, 32'hAAAA);
    chk("rt2_err", a_err, 0);
    step;
    a_drdata = 32'h5555; a_derr = 1'b1;
    #1;
    chk("rt3_rvalid", a_rvalid, 2'b01);
    chk("rt3_rdata", a_rdata, 32'h5555);
    chk("rt3_err", a_err, 1);
    step;
    a_dvalid = 1'b0; a_derr = 1'b0;
    chk("rt4_out", a_out, 0);

    // ---- lock: host1 stalled, host0 arrives later
    a_req = 2'b10; a_dgnt = 1'b0;
    #1;
    chk("lk0_addr", a_daddr, 32'h200);
    chk("lk0_dreq", a_dreq, 1);
    chk("lk0_gnt", a_gnt, 0);
    step;
    a_req = 2'b11;
    #1;
    chk("lk1_addr", a_daddr, 32'h200);
    chk("lk1_gnt", a_gnt, 0);
    step;
    #1;
    chk("lk2_addr", a_daddr, 32'h200);
    step;
    a_dgnt = 1'b1;
    #1;
    chk("lk3_gnt", a_gnt, 2'b10);
    chk("lk3_addr", a_daddr, 32'h200);
    step;
    #1;
    chk("lk4_gnt", a_gnt, 2'b01);
    chk("lk4_addr", a_daddr, 32'h100);
    step;
    a_req = '0; a_dgnt = 1'b0;
    chk("lk5_out", a_out, 2);
    a_dvalid = 1'b1;
    #1;
    chk("lk5_rvalid", a_rvalid, 2'b10);
    step;
    #1;
    chk("lk6_rvalid", a_rvalid, 2'b01);
    step;
    a_dvalid = 1'b0;
    chk("lk7_out", a_out, 0);

    // ---- lock released when the locked host withdraws
    a_req = 2'b10;
    #1;
    chk("ld0_addr", a_daddr, 32'h200);
    step;
    a_req = 2'b01;
    #1;
    chk("ld1_addr", a_daddr, 32'h100);
    chk("ld1_dreq", a_dreq, 1);
    step;
    a_req = '0;
    chk("ld2_out", a_out, 0);

    // ---- round-robin over three hosts
    b_req = 3'b111; b_dgnt = 1'b1;
    #1;
    chk("rr0_gnt", b_gnt, 3'b001);
    chk("rr0_addr", b_daddr, 32'h1000);
    step;
    b_dvalid = 1'b1;
    #1;
    chk("rr1_gnt", b_gnt, 3'b010);
    chk("rr1_addr", b_daddr, 32'h2000);
    chk("rr1_rvalid", b_rvalid, 3'b001);
    step;
    #1;
    chk("rr2_gnt", b_gnt, 3'b100);
    chk("rr2_addr", b_daddr, 32'h3000);
    chk("rr2_rvalid", b_rvalid, 3'b010);
    step;
    #1;
    chk("rr3_gnt", b_gnt, 3'b001);
    chk("rr3_rvalid", b_rvalid, 3'b100);
    step;
    #1;
    chk("rr4_gnt", b_gnt, 3'b010);
    step;
    #1;
    chk("rr5_gnt", b_gnt, 3'b100);
    chk("rr5_out", b_out, 1);
    step;
    b_req = '0;
    #1;
    chk("rr6_gnt", b_gnt, 0);
    chk("rr6_rvalid", b_rvalid, 3'b100);
    step;
    b_dvalid = 1'b0;
    chk("rr7_out", b_out, 0);
    b_req = 3'b101;
    #1;
    chk("rr7_gnt", b_gnt, 3'b001);
    step;
    #1;
    chk("rr8_wrap_gnt", b_gnt, 3'b100);
    step;
    b_req = '0; b_dvalid = 1'b1;
    #1;
    chk("rr9_rvalid", b_rvalid, 3'b001);
    step;
    #1;
    chk("rr10_rvalid", b_rvalid, 3'b100);
    step;
    b_dvalid = 1'b0;
    chk("rr11_out", b_out, 0);
    chk("rr11_spur", b_spur, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
